main_mem_arbiter: RTL and testbench

Shares the core's single main-memory port between the IFU (I-cache block fills) and the LSU (loads and stores). Arbitrates between the two requesters, keeps at most one transaction outstanding, and sequences each one through request and response phases. Routes each read response back to the requester that issued it and drops IFU fills squashed by a fetch redirect. Sits between `core` and the memory model/bus, replacing direct wiring of the `recv_main_mem_*` / `send_*_main_mem` ports.

---
 rtl/main_mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arb_streak.sv | 52 +++++
 rtl/main_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_main_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_arbiter_pkg.sv
// Shared types and global widths for the main-memory arbiter and its streak/grant helper.
package main_mem_arbiter_pkg;

  localparam int unsigned GLB_ADDR_WIDTH         = 32;
  localparam int unsigned GLB_WORD_WIDTH         = 32;
  localparam int unsigned ICACHE_DATA_BLOCK_SIZE = 128;
  localparam int unsigned MEM_SIZE_WIDTH         = 3;
  localparam int unsigned DEF_MAX_LSU_STREAK     = 4;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } mem_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } mem_arb_state_t;

  // Transaction attributes latched alongside address/data at grant time.
  typedef struct packed {
    mem_owner_t                owner;
    logic                      wr;
    logic [MEM_SIZE_WIDTH-1:0] size;
  } mem_req_meta_t;

endpackage

// File: rtl/mem_arb_streak.sv
// Grant pick between IFU and LSU plus the saturating count of LSU grants taken while the IFU waits.
module mem_arb_streak #(
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic clk,
  input  logic rst_aH,
  input  logic arb_idle_i,
  input  logic ifu_valid_i,
  input  logic ifu_flush_i,
  input  logic lsu_valid_i,
  output logic ifu_grant_c,
  output logic lsu_grant_c
);

  localparam int unsigned CNT_W = (MAX_LSU_STREAK < 1) ? 1 : $clog2(MAX_LSU_STREAK + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             streak_full;

  assign streak_full = (cnt_q == CNT_W'(MAX_LSU_STREAK));

  // A flushing IFU is never eligible, so the LSU may still take the slot that cycle.
  always_comb begin
    ifu_grant_c = 1'b0;
    lsu_grant_c = 1'b0;
    if (arb_idle_i) begin
      if (ifu_valid_i && !ifu_flush_i && (!lsu_valid_i || streak_full)) begin
        ifu_grant_c = 1'b1;
      end else if (lsu_valid_i) begin
        lsu_grant_c = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!ifu_valid_i || ifu_grant_c) begin
      cnt_d = '0;
    end else if (lsu_grant_c && !streak_full) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_aH) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares the single main-memory port between IFU block fills and LSU loads/stores,
// one transaction outstanding, responses routed back to the issuing requester.
module main_mem_arbiter
  import main_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = GLB_ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH     = GLB_WORD_WIDTH,
  parameter int unsigned BLOCK_WIDTH    = ICACHE_DATA_BLOCK_SIZE,
  parameter int unsigned MAX_LSU_STREAK = DEF_MAX_LSU_STREAK
) (
  input  logic                   clk,
  input  logic                   rst_aH,

  input  logic                   ifu_req_valid,
  output logic                   ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]  ifu_req_addr,
  input  logic                   ifu_flush,
  output logic                   ifu_resp_valid,
  output logic [ADDR_WIDTH-1:0]  ifu_resp_addr,
  output logic [BLOCK_WIDTH-1:0] ifu_resp_data,

  input  logic                   lsu_req_valid,
  output logic                   lsu_req_ready,
  input  logic                   lsu_req_wr,
  input  logic [ADDR_WIDTH-1:0]  lsu_req_addr,
  input  logic [2:0]             lsu_req_size,
  input  logic [WORD_WIDTH-1:0]  lsu_req_data,
  output logic                   lsu_resp_valid,
  output logic [ADDR_WIDTH-1:0]  lsu_resp_addr,
  output logic [BLOCK_WIDTH-1:0] lsu_resp_data,

  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_wr,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  output logic [2:0]             mem_req_size,
  output logic [WORD_WIDTH-1:0]  mem_req_data,
  input  logic                   mem_resp_valid,
  input  logic [BLOCK_WIDTH-1:0] mem_resp_data,

  output logic                   busy
);

  mem_arb_state_t         state_q, state_d;
  mem_req_meta_t          meta_q, meta_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WORD_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   squash_q, squash_d;
  logic                   ifu_rv_q, ifu_rv_d;
  logic [ADDR_WIDTH-1:0]  ifu_ra_q, ifu_ra_d;
  logic [BLOCK_WIDTH-1:0] ifu_rd_q, ifu_rd_d;
  logic                   lsu_rv_q, lsu_rv_d;
  logic [ADDR_WIDTH-1:0]  lsu_ra_q, lsu_ra_d;
  logic [BLOCK_WIDTH-1:0] lsu_rd_q, lsu_rd_d;
  logic                   ifu_grant, lsu_grant;
  logic                   ifu_flush_hit;

  mem_arb_streak #(
    .MAX_LSU_STREAK (MAX_LSU_STREAK)
  ) u_streak (
    .clk         (clk),
    .rst_aH      (rst_aH),
    .arb_idle_i  (state_q == ARB_IDLE),
    .ifu_valid_i (ifu_req_valid),
    .ifu_flush_i (ifu_flush),
    .lsu_valid_i (lsu_req_valid),
    .ifu_grant_c (ifu_grant),
    .lsu_grant_c (lsu_grant)
  );

  assign ifu_flush_hit = ifu_flush && (meta_q.owner == OWN_IFU);

  always_comb begin
    state_d  = state_q;
    meta_d   = meta_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    squash_d = squash_q;
    ifu_rv_d = 1'b0;
    ifu_ra_d = ifu_ra_q;
    ifu_rd_d = ifu_rd_q;
    lsu_rv_d = 1'b0;
    lsu_ra_d = lsu_ra_q;
    lsu_rd_d = lsu_rd_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (lsu_grant) begin
          meta_d  = '{owner: OWN_LSU, wr: lsu_req_wr, size: lsu_req_size};
          addr_d  = lsu_req_addr;
          wdata_d = lsu_req_data;
          state_d = ARB_REQ;
        end else if (ifu_grant) begin
          meta_d  = '{owner: OWN_IFU, wr: 1'b0, size: '0};
          addr_d  = ifu_req_addr;
          wdata_d = '0;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (ifu_flush_hit) squash_d = 1'b1;
        if (mem_req_ready) state_d = meta_q.wr ? ARB_IDLE : ARB_RESP;
      end
      ARB_RESP: begin
        if (ifu_flush_hit) squash_d = 1'b1;
        // A flush landing with the response itself still squashes the fill.
        if (mem_resp_valid) begin
          state_d = ARB_IDLE;
          if (meta_q.owner == OWN_LSU) begin
            lsu_rv_d = 1'b1;
            lsu_ra_d = addr_q;
            lsu_rd_d = mem_resp_data;
          end else if (!squash_d) begin
            ifu_rv_d = 1'b1;
            ifu_ra_d = addr_q;
            ifu_rd_d = mem_resp_data;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (state_d == ARB_IDLE) squash_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_aH) begin
      state_q  <= ARB_IDLE;
      meta_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      squash_q <= 1'b0;
      ifu_rv_q <= 1'b0;
      ifu_ra_q <= '0;
      ifu_rd_q <= '0;
      lsu_rv_q <= 1'b0;
      lsu_ra_q <= '0;
      lsu_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      meta_q   <= meta_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      squash_q <= squash_d;
      ifu_rv_q <= ifu_rv_d;
      ifu_ra_q <= ifu_ra_d;
      ifu_rd_q <= ifu_rd_d;
      lsu_rv_q <= lsu_rv_d;
      lsu_ra_q <= lsu_ra_d;
      lsu_rd_q <= lsu_rd_d;
    end
  end

  assign ifu_req_ready  = ifu_grant;
  assign lsu_req_ready  = lsu_grant;
  assign busy           = (state_q != ARB_IDLE);
  assign mem_req_valid  = (state_q == ARB_REQ);
  assign mem_req_wr     = meta_q.wr;
  assign mem_req_size   = meta_q.size;
  assign mem_req_addr   = addr_q;
  assign mem_req_data   = wdata_q;
  assign ifu_resp_valid = ifu_rv_q;
  assign ifu_resp_addr  = ifu_ra_q;
  assign ifu_resp_data  = ifu_rd_q;
  assign lsu_resp_valid = lsu_rv_q;
  assign lsu_resp_addr  = lsu_ra_q;
  assign lsu_resp_data  = lsu_rd_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed scenarios followed by randomized traffic against a transaction-level model of the arbiter.
module tb_main_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned WW   = 32;
  localparam int unsigned BW   = 128;
  localparam int unsigned MAXS = 4;
  localparam logic [2:0]  SZ_W = 3'b100;
  localparam logic [2:0]  SZ_H = 3'b010;
  localparam logic [2:0]  SZ_B = 3'b001;

  logic          clk = 1'b0;
  logic          rst_aH;
  logic          ifu_req_valid, ifu_req_ready, ifu_flush, ifu_resp_valid;
  logic [AW-1:0] ifu_req_addr, ifu_resp_addr;
  logic [BW-1:0] ifu_resp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_wr, lsu_resp_valid;
  logic [AW-1:0] lsu_req_addr, lsu_resp_addr;
  logic [2:0]    lsu_req_size;
  logic [WW-1:0] lsu_req_data;
  logic [BW-1:0] lsu_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_wr, mem_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [2:0]    mem_req_size;
  logic [WW-1:0] mem_req_data;
  logic [BW-1:0] mem_resp_data;
  logic          busy;

  main_mem_arbiter #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_WIDTH(BW), .MAX_LSU_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst_aH(rst_aH),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_flush(ifu_flush), .ifu_resp_valid(ifu_resp_valid), .ifu_resp_addr(ifu_resp_addr),
    .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wr(lsu_req_wr),
    .lsu_req_addr(lsu_req_addr), .lsu_req_size(lsu_req_size), .lsu_req_data(lsu_req_data),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_addr(lsu_resp_addr), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
    .mem_req_addr(mem_req_addr), .mem_req_size(mem_req_size), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] mdata(input logic [AW-1:0] a);
    return {a ^ 32'h1234_5678, ~a, a + 32'h1, a};
  endfunction

  task automatic clear_inputs();
    ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_flush = 1'b0;
    lsu_req_valid = 1'b0; lsu_req_wr = 1'b0; lsu_req_addr = '0; lsu_req_size = '0; lsu_req_data = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  // Plays an always-ready memory with immediate responses until the arbiter is idle again.
  task automatic run_to_idle(input string tag);
    int k;
    k = 0;
    mem_req_ready = 1'b1;
    while (busy && k < 20) begin
      mem_resp_valid = busy && !mem_req_valid;
      mem_resp_data  = mdata(mem_req_addr);
      tick();
      k++;
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    chk({tag, "_idle_bound"}, 256'(k < 20), 256'(1));
  endtask

  // Random-phase requester and model state
  logic [2:0]    sizes [3];
  bit            lp, ip, fl, lhs, ihs, iv, l_el, i_el, exp_ifu_rdy, exp_lsu_rdy;
  logic          lw;
  logic [AW-1:0] la, ia;
  logic [WW-1:0] ld;
  logic [2:0]    ls;
  bit            m_out, m_done, m_wr, m_ifu, m_sq;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_data;
  logic [2:0]    m_size;
  int            streak, rwait, g, k;
  bit            e_lrv, e_irv;
  logic [AW-1:0] e_ra;
  logic [BW-1:0] e_rd;

  initial begin
    sizes[0] = SZ_W; sizes[1] = SZ_H; sizes[2] = SZ_B;
    clear_inputs();
    rst_aH = 1'b1;
    tick(); tick();
    chk("rst_ctl", 256'({busy, mem_req_valid, mem_req_wr, ifu_resp_valid, lsu_resp_valid,
                         ifu_req_ready, lsu_req_ready}), 256'(0));
    chk("rst_payload", 256'({mem_req_size, mem_req_addr, mem_req_data}), 256'(0));
    chk("rst_resp", 256'({ifu_resp_addr, ifu_resp_data, lsu_resp_addr, lsu_resp_data}), 256'(0));
    rst_aH = 1'b0;

    // LSU load at 0x100, memory ready and responding immediately
    lsu_req_valid = 1'b1; lsu_req_wr = 1'b0; lsu_req_addr = 32'h100; lsu_req_size = SZ_W;
    mem_req_ready = 1'b1;
    #1;
    chk("ld_ready", 256'({ifu_req_ready, lsu_req_ready}), 256'(2'b01));
    tick();
    lsu_req_valid = 1'b0;
    chk("ld_mreq", 256'({mem_req_valid, mem_req_wr, mem_req_addr}), 256'({1'b1, 1'b0, 32'h100}));
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = mdata(32'h100);
    chk("ld_in_resp", 256'({busy, mem_req_valid}), 256'(2'b10));
    tick();
    mem_resp_valid = 1'b0;
    chk("ld_resp", 256'({lsu_resp_valid, ifu_resp_valid, lsu_resp_addr, lsu_resp_data}),
        256'({1'b1, 1'b0, 32'h100, mdata(32'h100)}));
    chk("ld_idle", 256'(busy), 256'(0));
    tick();
    chk("ld_pulse", 256'({lsu_resp_valid, ifu_resp_valid}), 256'(0));

    // Both requesters loading continuously: LSU x MAXS then IFU, repeating
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h200; ifu_req_valid = 1'b1; ifu_req_addr = 32'h2000;
    mem_req_ready = 1'b1;
    g = 0; k = 0;
    while (g < 10 && k < 100) begin
      mem_resp_valid = busy && !mem_req_valid;
      mem_resp_data  = mdata(mem_req_addr);
      #1;
      if (lsu_req_ready || ifu_req_ready) begin
        chk($sformatf("order_%0d", g), 256'({ifu_req_ready, lsu_req_ready}),
            256'((((g + 1) % (MAXS + 1)) == 0) ? 2'b10 : 2'b01));
        g++;
      end
      tick();
      k++;
    end
    chk("order_bound", 256'(g), 256'(10));
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;
    run_to_idle("order");

    // Store with memory back-pressure: payload held, no response
    lsu_req_valid = 1'b1; lsu_req_wr = 1'b1; lsu_req_addr = 32'h40; lsu_req_data = 32'hDEAD_BEEF;
    lsu_req_size = SZ_W; mem_req_ready = 1'b0;
    #1;
    chk("st_ready", 256'(lsu_req_ready), 256'(1));
    tick();
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_data = '0; lsu_req_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      chk($sformatf("st_hold_%0d", i),
          256'({mem_req_valid, mem_req_wr, mem_req_size, mem_req_addr, mem_req_data}),
          256'({1'b1, 1'b1, SZ_W, 32'h40, 32'hDEAD_BEEF}));
      tick();
    end
    mem_req_ready = 1'b0;
    chk("st_idle", 256'({busy, mem_req_valid, lsu_resp_valid, ifu_resp_valid}), 256'(0));
    tick();
    chk("st_no_resp", 256'({lsu_resp_valid, ifu_resp_valid}), 256'(0));

    // IFU fill flushed while in RESP: response suppressed, next IFU request served normally
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h3000; mem_req_ready = 1'b1;
    #1;
    chk("fl_grant", 256'(ifu_req_ready), 256'(1));
    tick();
    ifu_req_valid = 1'b0;
    tick();
    ifu_flush = 1'b1;
    chk("fl_in_resp", 256'({busy, mem_req_valid}), 256'(2'b10));
    tick();
    ifu_flush = 1'b0;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = mdata(32'h3000);
    tick();
    mem_resp_valid = 1'b0;
    chk("fl_suppressed", 256'({ifu_resp_valid, lsu_resp_valid, busy}), 256'(0));
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h3100;
    #1;
    chk("fl_regrant", 256'(ifu_req_ready), 256'(1));
    tick();
    ifu_req_valid = 1'b0;
    chk("fl_no_late", 256'(ifu_resp_valid), 256'(0));
    run_to_idle("fl");
    chk("fl_next_resp", 256'({ifu_resp_valid, ifu_resp_addr, ifu_resp_data}),
        256'({1'b1, 32'h3100, mdata(32'h3100)}));

    // Flush coinciding with an IFU request in IDLE blocks that cycle's grant only
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h4000; ifu_flush = 1'b1;
    #1;
    chk("fl_idle_nogrant", 256'({ifu_req_ready, lsu_req_ready}), 256'(0));
    tick();
    ifu_flush = 1'b0;
    #1;
    chk("fl_idle_grant", 256'({busy, ifu_req_ready}), 256'(2'b01));
    tick();
    ifu_req_valid = 1'b0;
    run_to_idle("fl_idle");

    // Reset while a load waits in RESP, then a stray memory response
    lsu_req_valid = 1'b1; lsu_req_wr = 1'b0; lsu_req_addr = 32'h500; mem_req_ready = 1'b1;
    tick();
    lsu_req_valid = 1'b0;
    tick();
    chk("rst_mid_in_resp", 256'({busy, mem_req_valid}), 256'(2'b10));
    rst_aH = 1'b1;
    tick();
    rst_aH = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = mdata(32'h500);
    tick();
    mem_resp_valid = 1'b0;
    chk("rst_mid_ctl", 256'({busy, mem_req_valid, mem_req_wr, mem_req_size, mem_req_addr, mem_req_data,
                             lsu_resp_valid, ifu_resp_valid, ifu_req_ready, lsu_req_ready}), 256'(0));
    chk("rst_mid_resp", 256'({lsu_resp_addr, lsu_resp_data}), 256'(0));
    tick();
    chk("rst_mid_quiet", 256'({busy, lsu_resp_valid, ifu_resp_valid}), 256'(0));

    // Randomized traffic against the transaction-level model
    clear_inputs();
    rst_aH = 1'b1;
    tick();
    rst_aH = 1'b0;
    lp = 0; ip = 0; m_out = 0; m_done = 0; m_sq = 0; m_ifu = 0; m_wr = 0;
    m_addr = '0; m_data = '0; m_size = '0; lw = 0; la = '0; ld = '0; ls = '0; ia = '0;
    streak = 0; rwait = 0; e_lrv = 0; e_irv = 0; e_ra = '0; e_rd = '0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_busy", 256'(busy), 256'(m_out));
      chk("rnd_mreq_valid", 256'(mem_req_valid), 256'(m_out && !m_done));
      if (m_out && !m_done) begin
        chk("rnd_mreq_addr", 256'({mem_req_wr, mem_req_addr}), 256'({m_wr, m_addr}));
        if (!m_ifu)
          chk("rnd_mreq_lsu", 256'({mem_req_size, mem_req_data}), 256'({m_size, m_data}));
      end
      chk("rnd_lsu_rv", 256'(lsu_resp_valid), 256'(e_lrv));
      chk("rnd_ifu_rv", 256'(ifu_resp_valid), 256'(e_irv));
      if (e_lrv) chk("rnd_lsu_resp", 256'({lsu_resp_addr, lsu_resp_data}), 256'({e_ra, e_rd}));
      if (e_irv) chk("rnd_ifu_resp", 256'({ifu_resp_addr, ifu_resp_data}), 256'({e_ra, e_rd}));

      if (!lp && $urandom_range(0, 2) == 0) begin
        lp = 1; lw = 1'($urandom_range(0, 1)); la = $urandom & 32'hFFFF_FFFC;
        ld = $urandom; ls = sizes[$urandom_range(0, 2)];
      end
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; ia = $urandom & 32'hFFFF_FFF0;
      end
      fl = ($urandom_range(0, 15) == 0);
      if (fl && ip) ia = $urandom & 32'hFFFF_FFF0;
      lsu_req_valid = lp; lsu_req_wr = lw; lsu_req_addr = la; lsu_req_data = ld; lsu_req_size = ls;
      ifu_req_valid = ip; ifu_req_addr = ia; ifu_flush = fl;
      mem_req_ready = 1'($urandom_range(0, 1));
      if (m_out && m_done) begin
        mem_resp_valid = (rwait == 0);
        mem_resp_data  = mdata(m_addr);
        if (rwait > 0) rwait--;
      end else begin
        mem_resp_valid = ($urandom_range(0, 7) == 0);
        mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;

      l_el = lp;
      i_el = ip && !fl;
      exp_ifu_rdy = !m_out && i_el && (!l_el || streak == int'(MAXS));
      exp_lsu_rdy = !m_out && l_el && !(i_el && streak == int'(MAXS));
      chk("rnd_ifu_ready", 256'(ifu_req_ready), 256'(exp_ifu_rdy));
      chk("rnd_lsu_ready", 256'(lsu_req_ready), 256'(exp_lsu_rdy));
      lhs = lsu_req_valid && lsu_req_ready;
      ihs = ifu_req_valid && ifu_req_ready;
      iv  = ip;

      e_lrv = 0; e_irv = 0;
      if (m_out && m_ifu && fl) m_sq = 1;
      if (m_out && m_done && mem_resp_valid) begin
        if (m_ifu) e_irv = !m_sq;
        else       e_lrv = 1;
        e_ra = m_addr; e_rd = mem_resp_data; m_out = 0;
      end else if (m_out && !m_done && mem_req_ready) begin
        if (m_wr) m_out = 0;
        else begin
          m_done = 1; rwait = $urandom_range(0, 3);
        end
      end
      if (lhs) begin
        m_out = 1; m_done = 0; m_ifu = 0; m_wr = lw; m_addr = la; m_data = ld; m_size = ls;
        m_sq = 0; lp = 0;
      end else if (ihs) begin
        m_out = 1; m_done = 0; m_ifu = 1; m_wr = 0; m_addr = ia; m_data = '0; m_size = '0;
        m_sq = 0; ip = 0;
      end
      if (!iv || ihs) streak = 0;
      else if (lhs && streak < int'(MAXS)) streak++;

      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
